// File: rtl/apb_arbiter.sv
// Two-requester APB arbiter sharing one fabric target port.
// Simultaneous requests are resolved round-robin; one transfer at a time.
//
// state  | meaning
// IDLE   | no transfer on the fabric; arbitrate pending requests
// SETUP  | APB setup phase for the granted requester
// ACCESS | APB access phase; hold until fab_t_pready
module apb_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a0_i_psel,
  input  logic              a0_i_penable,
  input  logic [ADDR_W-1:0] a0_i_paddr,
  input  logic              a0_i_pwrite,
  input  logic [31:0]       a0_i_pwdata,
  input  logic [3:0]        a0_i_pwstrb,
  output logic              a0_i_pready,
  output logic [31:0]       a0_i_prdata,
  output logic              a0_i_pslverr,
  input  logic              a1_i_psel,
  input  logic              a1_i_penable,
  input  logic [ADDR_W-1:0] a1_i_paddr,
  input  logic              a1_i_pwrite,
  input  logic [31:0]       a1_i_pwdata,
  input  logic [3:0]        a1_i_pwstrb,
  output logic              a1_i_pready,
  output logic [31:0]       a1_i_prdata,
  output logic              a1_i_pslverr,
  output logic              fab_t_psel,
  output logic              fab_t_penable,
  output logic [ADDR_W-1:0] fab_t_paddr,
  output logic              fab_t_pwrite,
  output logic [31:0]       fab_t_pwdata,
  output logic [3:0]        fab_t_pwstrb,
  input  logic              fab_t_pready,
  input  logic [31:0]       fab_t_prdata,
  input  logic              fab_t_pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state;
  logic   gnt;
  logic   prio;
  logic   psel_q;
  logic   penable_q;
  logic   sel0;
  logic   sel1;
  logic   unused_penable;

  // Requester penable carries no information the sequencer needs.
  assign unused_penable = a0_i_penable ^ a1_i_penable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      prio      <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a0_i_psel | a1_i_psel) begin
            gnt    <= (a0_i_psel & a1_i_psel) ? prio : a1_i_psel;
            state  <= SETUP;
            psel_q <= 1'b1;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (fab_t_pready) begin
            state     <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            prio      <= ~gnt;
          end
        end
        default: begin
          state     <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign fab_t_psel    = psel_q;
  assign fab_t_penable = penable_q;

  always_comb begin
    fab_t_paddr  = '0;
    fab_t_pwrite = 1'b0;
    fab_t_pwdata = '0;
    fab_t_pwstrb = '0;
    if (psel_q) begin
      if (gnt) begin
        fab_t_paddr  = a1_i_paddr;
        fab_t_pwrite = a1_i_pwrite;
        fab_t_pwdata = a1_i_pwdata;
        fab_t_pwstrb = a1_i_pwstrb;
      end else begin
        fab_t_paddr  = a0_i_paddr;
        fab_t_pwrite = a0_i_pwrite;
        fab_t_pwdata = a0_i_pwdata;
        fab_t_pwstrb = a0_i_pwstrb;
      end
    end
  end

  // Responses reach only the granted requester, and only during ACCESS.
  assign sel0 = penable_q & ~gnt;
  assign sel1 = penable_q & gnt;

  assign a0_i_pready  = sel0 & fab_t_pready;
  assign a0_i_prdata  = sel0 ? fab_t_prdata : '0;
  assign a0_i_pslverr = sel0 & fab_t_pslverr;
  assign a1_i_pready  = sel1 & fab_t_pready;
  assign a1_i_prdata  = sel1 ? fab_t_prdata : '0;
  assign a1_i_pslverr = sel1 & fab_t_pslverr;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: transfer-schedule reference model plus a response
// scoreboard fed by the target model and drained when a requester sees pready.
module tb_apb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        r_psel[2];
  logic [31:0] r_paddr[2];
  logic        r_pwrite[2];
  logic [31:0] r_pwdata[2];
  logic [3:0]  r_pwstrb[2];

  logic        a0_i_pready, a1_i_pready, a0_i_pslverr, a1_i_pslverr;
  logic [31:0] a0_i_prdata, a1_i_prdata;
  logic        fab_t_psel, fab_t_penable, fab_t_pwrite;
  logic [31:0] fab_t_paddr, fab_t_pwdata;
  logic [3:0]  fab_t_pwstrb;

  logic        tgt_pready  = 1'b0;
  logic [31:0] tgt_prdata  = '0;
  logic        tgt_pslverr = 1'b0;

  apb_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .a0_i_psel(r_psel[0]), .a0_i_penable(1'b0), .a0_i_paddr(r_paddr[0]),
    .a0_i_pwrite(r_pwrite[0]), .a0_i_pwdata(r_pwdata[0]), .a0_i_pwstrb(r_pwstrb[0]),
    .a0_i_pready(a0_i_pready), .a0_i_prdata(a0_i_prdata), .a0_i_pslverr(a0_i_pslverr),
    .a1_i_psel(r_psel[1]), .a1_i_penable(1'b0), .a1_i_paddr(r_paddr[1]),
    .a1_i_pwrite(r_pwrite[1]), .a1_i_pwdata(r_pwdata[1]), .a1_i_pwstrb(r_pwstrb[1]),
    .a1_i_pready(a1_i_pready), .a1_i_prdata(a1_i_prdata), .a1_i_pslverr(a1_i_pslverr),
    .fab_t_psel(fab_t_psel), .fab_t_penable(fab_t_penable), .fab_t_paddr(fab_t_paddr),
    .fab_t_pwrite(fab_t_pwrite), .fab_t_pwdata(fab_t_pwdata), .fab_t_pwstrb(fab_t_pwstrb),
    .fab_t_pready(tgt_pready), .fab_t_prdata(tgt_prdata), .fab_t_pslverr(tgt_pslverr)
  );

  typedef struct {
    bit          who;
    logic [31:0] rdata;
    logic        err;
    logic [68:0] req;
  } exp_t;

  exp_t exp_q[$];
  int   comp_who_q[$];
  int   comp_cyc_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference schedule: a grant decided in cycle g with w wait states puts
  // SETUP at g+1, ACCESS over g+2..g+2+w and completes at done = g+2+w.
  int g_cyc    = -3;
  int done_cyc = -1;
  bit m_gnt    = 1'b0;
  bit m_prio   = 1'b0;

  int          force_w     = -1;
  bit          force_resp  = 1'b0;
  logic [31:0] force_rdata = '0;
  logic        force_err   = 1'b0;

  int          lat_b[2];
  logic [31:0] rd_b[2];
  logic        er_b[2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Target: random read data/error every cycle, pready only on scheduled completion.
  always @(posedge clk) begin
    exp_t e;
    #1;
    tgt_prdata  = $urandom;
    tgt_pslverr = 1'($urandom_range(1, 0));
    tgt_pready  = !rst && (cyc == done_cyc);
    if (tgt_pready) begin
      if (force_resp) begin
        tgt_prdata  = force_rdata;
        tgt_pslverr = force_err;
      end
      e.who   = m_gnt;
      e.rdata = tgt_prdata;
      e.err   = tgt_pslverr;
      e.req   = {r_paddr[m_gnt], r_pwrite[m_gnt], r_pwdata[m_gnt], r_pwstrb[m_gnt]};
      exp_q.push_back(e);
    end
  end

  // Cycle-level checks against the schedule, then arbitration for this cycle.
  always @(negedge clk) begin
    int c;
    bit ps, pen;
    logic [68:0] ereq;
    logic [33:0] er0, er1;
    if (rst) begin
      g_cyc = -3; done_cyc = -1; m_gnt = 1'b0; m_prio = 1'b0;
      exp_q.delete();
    end else begin
      c   = cyc;
      ps  = (c > g_cyc) && (c <= done_cyc);
      pen = (c >= g_cyc + 2) && (c <= done_cyc);
      chk("fab_psel", fab_t_psel, ps);
      chk("fab_penable", fab_t_penable, pen);
      ereq = ps ? {r_paddr[m_gnt], r_pwrite[m_gnt], r_pwdata[m_gnt], r_pwstrb[m_gnt]} : '0;
      chk("fab_req", {fab_t_paddr, fab_t_pwrite, fab_t_pwdata, fab_t_pwstrb}, ereq);
      er0 = (pen && !m_gnt) ? {tgt_pready, tgt_prdata, tgt_pslverr} : '0;
      er1 = (pen &&  m_gnt) ? {tgt_pready, tgt_prdata, tgt_pslverr} : '0;
      chk("a0_resp", {a0_i_pready, a0_i_prdata, a0_i_pslverr}, er0);
      chk("a1_resp", {a1_i_pready, a1_i_prdata, a1_i_pslverr}, er1);
      if (c == done_cyc) begin
        m_prio = !m_gnt;
      end else if (c > done_cyc && (r_psel[0] || r_psel[1])) begin
        m_gnt    = (r_psel[0] && r_psel[1]) ? m_prio : r_psel[1];
        g_cyc    = c;
        done_cyc = c + 2 + ((force_w >= 0) ? force_w : int'($urandom_range(3, 0)));
      end
    end
  end

  // Scoreboard monitor: every requester completion must match the queued response.
  always @(negedge clk) begin
    exp_t e;
    bit who;
    if (!rst && (a0_i_pready || a1_i_pready)) begin
      who = a1_i_pready;
      chk("sb_one_pready", a0_i_pready & a1_i_pready, 1'b0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: pready from requester %0d with nothing expected (cycle %0d)", who, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_who", who, e.who);
        chk("sb_rdata", who ? a1_i_prdata : a0_i_prdata, e.rdata);
        chk("sb_err", who ? a1_i_pslverr : a0_i_pslverr, e.err);
        chk("sb_req", {fab_t_paddr, fab_t_pwrite, fab_t_pwdata, fab_t_pwstrb}, e.req);
      end
      comp_who_q.push_back(who);
      comp_cyc_q.push_back(cyc);
    end
  end

  // Issue one transfer from requester i; returns at posedge+1 after completion.
  task automatic do_req(input int i, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output int lat, output logic [31:0] rd, output logic er);
    int t0;
    bit got;
    r_psel[i] = 1'b1; r_paddr[i] = addr; r_pwrite[i] = wr;
    r_pwdata[i] = wd; r_pwstrb[i] = st;
    t0 = cyc; got = 1'b0; lat = -1; rd = '0; er = 1'b0;
    for (int k = 0; k < 80 && !got; k++) begin
      @(negedge clk);
      if ((i == 0 && a0_i_pready) || (i == 1 && a1_i_pready)) begin
        got = 1'b1;
        lat = cyc - t0;
        rd  = (i == 0) ? a0_i_prdata : a1_i_prdata;
        er  = (i == 0) ? a0_i_pslverr : a1_i_pslverr;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: requester %0d saw no pready within 80 cycles", i);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    bit saved_prio;
    for (int i = 0; i < 2; i++) begin
      r_psel[i] = 1'b0; r_paddr[i] = '0; r_pwrite[i] = 1'b0;
      r_pwdata[i] = '0; r_pwstrb[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {fab_t_psel, fab_t_penable, fab_t_paddr, a0_i_pready, a1_i_pready}, '0);
    @(posedge clk); #1;

    // Single zero-wait read from a0.
    force_w = 0; force_resp = 1'b1; force_rdata = 32'hDEAD_BEEF; force_err = 1'b0;
    do_req(0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, lat_b[0], rd_b[0], er_b[0]);
    r_psel[0] = 1'b0;
    chk("t1_latency", lat_b[0], 2);
    chk("t1_rdata", rd_b[0], 32'hDEAD_BEEF);

    // Simultaneous writes right after reset: a0 first, then a1.
    do_reset();
    force_resp = 1'b0; force_w = -1;
    comp_who_q.delete();
    fork
      begin do_req(0, 32'h100, 1'b1, 32'h11, 4'hF, lat_b[0], rd_b[0], er_b[0]); r_psel[0] = 1'b0; end
      begin do_req(1, 32'h200, 1'b1, 32'h22, 4'hF, lat_b[1], rd_b[1], er_b[1]); r_psel[1] = 1'b0; end
    join
    chk("t2_count", comp_who_q.size(), 2);
    if (comp_who_q.size() == 2) begin
      chk("t2_first", comp_who_q[0], 0);
      chk("t2_second", comp_who_q[1], 1);
    end

    // Continuous contention, zero-wait target: 0,1,0,1 every 3 cycles.
    force_w = 0;
    comp_who_q.delete(); comp_cyc_q.delete();
    fork
      begin
        for (int n = 0; n < 2; n++) do_req(0, $urandom, 1'b1, $urandom, 4'hF, lat_b[0], rd_b[0], er_b[0]);
        r_psel[0] = 1'b0;
      end
      begin
        for (int n = 0; n < 2; n++) do_req(1, $urandom, 1'b0, 32'h0, 4'h0, lat_b[1], rd_b[1], er_b[1]);
        r_psel[1] = 1'b0;
      end
    join
    chk("t3_count", comp_who_q.size(), 4);
    if (comp_who_q.size() == 4) begin
      for (int n = 0; n < 4; n++) chk("t3_order", comp_who_q[n], n % 2);
      for (int n = 1; n < 4; n++) chk("t3_period", comp_cyc_q[n] - comp_cyc_q[n-1], 3);
    end

    // Three wait states and an error response to a1.
    force_w = 3; force_resp = 1'b1; force_rdata = 32'h5A5A_1234; force_err = 1'b1;
    do_req(1, 32'h0000_0ABC, 1'b0, 32'h0, 4'h0, lat_b[1], rd_b[1], er_b[1]);
    r_psel[1] = 1'b0;
    chk("t4_latency", lat_b[1], 5);
    chk("t4_err", er_b[1], 1'b1);
    chk("t4_rdata", rd_b[1], 32'h5A5A_1234);
    force_resp = 1'b0;

    // Reset asserted during ACCESS, then a1 alone.
    force_w = 2;
    r_psel[0] = 1'b1; r_paddr[0] = 32'hCAFE_0000; r_pwrite[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    chk("t5_access_before", {fab_t_psel, fab_t_penable}, 2'b11);
    rst = 1'b1;
    #1;
    chk("t5_rst_fab", {fab_t_psel, fab_t_penable, fab_t_paddr}, '0);
    r_psel[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    force_w = 0;
    comp_who_q.delete();
    do_req(1, 32'h0000_7700, 1'b0, 32'h0, 4'h0, lat_b[1], rd_b[1], er_b[1]);
    r_psel[1] = 1'b0;
    chk("t5_latency", lat_b[1], 2);
    chk("t5_who", (comp_who_q.size() == 1) ? comp_who_q[0] : -1, 1);

    // Idle stability: outputs checked every cycle by the schedule monitor.
    saved_prio = m_prio;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_prio", dut.prio, saved_prio);

    // Randomised traffic from both requesters.
    force_w = -1;
    fork
      for (int n = 0; n < 25; n++) begin
        int gap;
        gap = $urandom_range(2, 0);
        if (gap > 0) begin
          r_psel[0] = 1'b0;
          repeat (gap) @(posedge clk);
          #1;
        end
        v = $urandom;
        do_req(0, v, 1'($urandom_range(1, 0)), $urandom, 4'($urandom), lat_b[0], rd_b[0], er_b[0]);
        if (n == 24) r_psel[0] = 1'b0;
      end
      for (int n = 0; n < 25; n++) begin
        int gap;
        gap = $urandom_range(2, 0);
        if (gap > 0) begin
          r_psel[1] = 1'b0;
          repeat (gap) @(posedge clk);
          #1;
        end
        do_req(1, $urandom, 1'($urandom_range(1, 0)), $urandom, 4'($urandom), lat_b[1], rd_b[1], er_b[1]);
        if (n == 24) r_psel[1] = 1'b0;
      end
    join

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Two-initiator to one-target APB arbiter that shares the APB fabric's single initiator port between two requesters, e.g. instruction fetch and load/store. It sits directly in front of the fabric's core port. It serialises transfers with a three-state sequencer and resolves simultaneous requests round-robin. Requester signals are held stable per APB rules and are muxed onto the target port while that requester holds the grant.

## Interface
- ADDR_W, 32: address width on all ports.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a0_i_psel / a1_i_psel  input  1  requester select (request).
- a0_i_penable / a1_i_penable  input  1  requester enable; ignored by the arbiter.
- a0_i_paddr / a1_i_paddr  input  ADDR_W  address.
- a0_i_pwrite / a1_i_pwrite  input  1  write flag.
- a0_i_pwdata / a1_i_pwdata  input  32  write data.
- a0_i_pwstrb / a1_i_pwstrb  input  4  byte strobes.
- a0_i_pready / a1_i_pready  output  1  completion to requester.
- a0_i_prdata / a1_i_prdata  output  32  read data.
- a0_i_pslverr / a1_i_pslverr  output  1  error.
- fab_t_psel, fab_t_penable  output  1 each  target select and enable.
- fab_t_paddr  output  ADDR_W; fab_t_pwrite  output  1; fab_t_pwdata  output  32; fab_t_pwstrb  output  4.
- fab_t_pready, fab_t_pslverr  input  1 each; fab_t_prdata  input  32.

## Operation
- Registered state: FSM {IDLE, SETUP, ACCESS}, grant index gnt (1 bit), round-robin priority pointer prio (1 bit).
- IDLE: fab_t_psel=0, fab_t_penable=0.
  - If exactly one of a0_i_psel/a1_i_psel is 1, gnt ← that index.
  - If both are 1, gnt ← prio.
  - If any request is present → SETUP.
- SETUP: fab_t_psel=1, fab_t_penable=0. Go to ACCESS unconditionally.
- ACCESS: fab_t_psel=1, fab_t_penable=1. Stay in ACCESS while fab_t_pready=0.
  - On fab_t_pready=1: go to IDLE and set prio ← ~gnt.
- Request mux: fab_t_paddr, fab_t_pwrite, fab_t_pwdata and fab_t_pwstrb are driven combinationally from requester gnt whenever the state is not IDLE. In IDLE they are driven 0.
- Response routing:
  - a{gnt}_i_pready = fab_t_pready only while in ACCESS; otherwise 0.
  - a{gnt}_i_prdata = fab_t_prdata and a{gnt}_i_pslverr = fab_t_pslverr only in ACCESS; otherwise 0.
  - The non-granted requester always sees pready=0, prdata=0, pslverr=0.
- pslverr from the target is passed through unmodified. The arbiter never generates errors.
- A requester dropping psel mid-transfer violates APB; behaviour is undefined and need not be checked.
- Reset (asynchronous, including mid-transfer): state=IDLE, gnt=0, prio=0. All outputs go to 0 immediately, so fab_t_psel and fab_t_penable are deasserted without waiting for pready.

## Timing
- Arbitration latency: a request seen in IDLE at cycle N produces fab SETUP at N+1 and ACCESS at N+2.
- Earliest completion is at N+2, when the target gives zero wait states. The requester therefore sees exactly one extra wait state relative to a direct connection.
- After every completion the FSM returns to IDLE for one cycle. The minimum transfer period on the fabric is 3 cycles.
- The other requester pending during a transfer is granted in the IDLE cycle right after completion, because prio now points at it. Back-to-back requests from both requesters therefore alternate strictly.
- A requester's psel that is still high in its own completion cycle is not re-arbitrated. Arbitration happens only in IDLE, by which time the requester has moved to its next transfer or dropped psel.
- No combinational path from a{0,1}_i_psel to fab_t_psel. Request data and response paths are combinational.

## Test plan
- Single read from a0, zero-wait target:
  - a0 psel at cycle 0 with paddr=0x8000_0004 → fab SETUP at cycle 1, ACCESS at cycle 2.
  - Target returns prdata=0xDEADBEEF with pready=1 at cycle 2 → a0_i_pready=1 and a0_i_prdata=0xDEADBEEF at cycle 2; a1 outputs stay 0.
- Simultaneous requests after reset: a0 writes 0x11 to 0x100 and a1 writes 0x22 to 0x200 → a0 is granted first (prio=0), then a1. Expect fab addresses 0x100 then 0x200, with IDLE in between.
- Continuous contention over 4 transfers, both requesters always requesting → grant order 0,1,0,1 with a 3-cycle period per transfer.
- Wait states: target holds pready=0 for 3 ACCESS cycles with pslverr=1 on completion → a1_i_pready is low for those 3 cycles, then a1_i_pready=1 and a1_i_pslverr=1. fab_t_paddr stays stable throughout.
- Reset asserted in ACCESS → fab_t_psel and fab_t_penable drop to 0 in the same cycle. After release, a1 alone is requesting and is granted with SETUP one cycle after IDLE.
- Idle stability: no psel for 20 cycles → all outputs remain 0 and prio is unchanged.
